// File: rtl/matrix_out_packer_if.sv
// Row-sum input and packed-word output bundle between the matrix-vector
// multiplier, the packer, and the hash framing stage.
interface matrix_out_packer_if #(
    parameter int SUM_W = 16
);
    logic             start;
    logic [255:0]     hash_in;
    logic             row_valid;
    logic [SUM_W-1:0] row_sum;
    logic             we_out;
    logic [63:0]      dout;
    logic             busy;
    logic             done;
    logic             protocol_err;

    modport master (
        output start, hash_in, row_valid, row_sum,
        input  we_out, dout, busy, done, protocol_err
    );

    modport slave (
        input  start, hash_in, row_valid, row_sum,
        output we_out, dout, busy, done, protocol_err
    );
endinterface

// File: rtl/matrix_out_packer.sv
// Packs one nibble per row sum into four 64-bit words per job, XORed with
// the matching 64-bit slice of the captured first-pass hash.
module matrix_out_packer #(
    parameter int SUM_W = 16,
    parameter int SHIFT = 10,
    parameter int ROWS  = 64
) (
    input logic                 clk,
    input logic                 rst,
    matrix_out_packer_if.slave  bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t       state;
    logic [5:0]   cnt;
    logic [63:0]  acc;
    logic [255:0] hash_reg;
    logic [3:0]   nibble;
    logic [63:0]  acc_next;
    logic [63:0]  hash_word;

    assign nibble   = bus.row_sum[SHIFT+3:SHIFT];
    assign acc_next = {acc[59:0], nibble};

    // Word k takes the k-th 64-bit slice counting down from the hash MSBs.
    always_comb begin
        hash_word = hash_reg[255:192];
        case (cnt[5:4])
            2'd0: hash_word = hash_reg[255:192];
            2'd1: hash_word = hash_reg[191:128];
            2'd2: hash_word = hash_reg[127:64];
            2'd3: hash_word = hash_reg[63:0];
            default: hash_word = hash_reg[255:192];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            acc              <= '0;
            hash_reg         <= '0;
            bus.we_out       <= 1'b0;
            bus.dout         <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.protocol_err <= 1'b0;
        end else begin
            bus.we_out       <= 1'b0;
            bus.done         <= 1'b0;
            bus.protocol_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Rows outside a job are dropped, only flagged.
                    if (bus.row_valid)
                        bus.protocol_err <= 1'b1;
                    if (bus.start) begin
                        hash_reg <= bus.hash_in;
                        cnt      <= '0;
                        acc      <= '0;
                        bus.busy <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.row_valid) begin
                        acc <= acc_next;
                        cnt <= cnt + 6'd1;
                        if (cnt[3:0] == 4'hF) begin
                            bus.we_out <= 1'b1;
                            bus.dout   <= acc_next ^ hash_word;
                        end
                        if (cnt == 6'(ROWS - 1)) begin
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
